// File: rtl/load_store_unit.sv
// Load/store unit: zero-latency loads with byte/halfword extraction and extension,
// single-cycle SW, and a 3-cycle read-modify-write for SB/SH. Optional macro
// LSU_MISALIGN_TRAP_EN suppresses misaligned accesses and raises a sticky flag.
module load_store_unit (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWE,
  input  logic [31:0] MemRData,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {IDLE, MERGE, WRITE} state_t;

  state_t      state, next;
  logic [31:0] cap_addr, cap_data, old_word, merged;
  logic        cap_half;
  logic        st_valid, ld_valid, start_rmw, trap;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // A simultaneous store request masks the load entirely.
  assign st_valid  = MemWrite & (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010);
  assign ld_valid  = ~MemWrite & MemRead &
                     (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010 ||
                      Funct3 == 3'b100 || Funct3 == 3'b101);
  assign start_rmw = st_valid & ~trap & (Funct3 != 3'b010);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal, mis_err;

  assign misal = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                 ((Funct3 == 3'b010) & (ALUResult[1:0] != 2'b00));
  assign trap  = (st_valid | ld_valid) & misal & (state == IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    mis_err <= 1'b0;
    else if (trap) mis_err <= 1'b1;
  end

  assign MisalignErr = mis_err;
`else
  assign trap        = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  // Halfword lane uses addr[1] only, so unaligned halfwords truncate to natural alignment.
  assign ld_byte = MemRData[{ALUResult[1:0], 3'b000} +: 8];
  assign ld_half = MemRData[{ALUResult[1], 4'b0000} +: 16];

  always_comb begin
    merged = old_word;
    if (cap_half) merged[{cap_addr[1], 4'b0000} +: 16] = cap_data[15:0];
    else          merged[{cap_addr[1:0], 3'b000} +: 8] = cap_data[7:0];
  end

  always_comb begin
    next     = state;
    Stall    = 1'b0;
    MemWE    = 1'b0;
    MemWData = WriteData;
    MemAddr  = {2'b00, ALUResult[31:2]};
    ReadData = '0;
    case (state)
      IDLE: begin
        if (st_valid && !trap) begin
          if (Funct3 == 3'b010) begin
            MemWE = 1'b1;
          end else begin
            Stall = 1'b1;
            next  = MERGE;
          end
        end
        if (ld_valid && !trap) begin
          case (Funct3)
            3'b000:  ReadData = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ReadData = {24'h000000, ld_byte};
            3'b001:  ReadData = {{16{ld_half[15]}}, ld_half};
            3'b101:  ReadData = {16'h0000, ld_half};
            3'b010:  ReadData = MemRData;
            default: ReadData = '0;
          endcase
        end
      end
      MERGE: begin
        MemAddr = {2'b00, cap_addr[31:2]};
        Stall   = 1'b1;
        next    = WRITE;
      end
      WRITE: begin
        MemAddr  = {2'b00, cap_addr[31:2]};
        MemWData = merged;
        MemWE    = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
    // Outputs are forced quiet for the whole reset window, not just after the edge.
    if (!RST_N) begin
      Stall    = 1'b0;
      MemWE    = 1'b0;
      ReadData = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_data <= '0;
      cap_half <= 1'b0;
      old_word <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start_rmw) begin
        cap_addr <= ALUResult;
        cap_data <= WriteData;
        cap_half <= Funct3[0];
      end
      if (state == MERGE) old_word <= MemRData;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of combinational load vectors plus
// directed store, read-modify-write, reset-abort and misalignment sequences.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] ALUResult, WriteData, ReadData, MemAddr, MemWData, MemRData;
  logic        MemWrite, MemRead, Stall, MemWE, MisalignErr;
  logic [2:0]  Funct3;

  logic [31:0] mem [16];
  int checks   = 0;
  int failures = 0;

  load_store_unit dut (
    .CLK(CLK), .RST_N(RST_N), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Funct3(Funct3), .ReadData(ReadData),
    .Stall(Stall), .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE),
    .MemRData(MemRData), .MisalignErr(MisalignErr)
  );

  always #5 CLK = ~CLK;

  assign MemRData = mem[MemAddr[3:0]];
  always @(posedge CLK) if (MemWE) mem[MemAddr[3:0]] = MemWData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        rd;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [17];

  initial begin
    vecs[0]  = '{32'h00, 3'b000, 1'b1, 32'h0000F080, 32'hFFFFFF80};
    vecs[1]  = '{32'h00, 3'b100, 1'b1, 32'h0000F080, 32'h00000080};
    vecs[2]  = '{32'h00, 3'b001, 1'b1, 32'h0000F080, 32'hFFFFF080};
    vecs[3]  = '{32'h00, 3'b101, 1'b1, 32'h0000F080, 32'h0000F080};
    vecs[4]  = '{32'h00, 3'b010, 1'b1, 32'h0000F080, 32'h0000F080};
    vecs[5]  = '{32'h01, 3'b000, 1'b1, 32'h0000F080, 32'hFFFFFFF0};
    vecs[6]  = '{32'h04, 3'b000, 1'b1, 32'h11223344, 32'h00000044};
    vecs[7]  = '{32'h07, 3'b100, 1'b1, 32'h11223344, 32'h00000011};
    vecs[8]  = '{32'h06, 3'b001, 1'b1, 32'h11223344, 32'h00001122};
    vecs[9]  = '{32'h2E, 3'b001, 1'b1, 32'h80018002, 32'hFFFF8001};
    vecs[10] = '{32'h2C, 3'b101, 1'b1, 32'h80018002, 32'h00008002};
    vecs[11] = '{32'h00, 3'b011, 1'b1, 32'h0000F080, 32'h00000000};
    vecs[12] = '{32'h00, 3'b110, 1'b1, 32'h0000F080, 32'h00000000};
    vecs[13] = '{32'h00, 3'b111, 1'b1, 32'h0000F080, 32'h00000000};
    vecs[14] = '{32'h00, 3'b010, 1'b0, 32'h0000F080, 32'h00000000};
    vecs[15] = '{32'h3F, 3'b000, 1'b1, 32'h7F000000, 32'h0000007F};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[16] = '{32'h03, 3'b001, 1'b1, 32'hABCD1234, 32'h00000000};
`else
    vecs[16] = '{32'h03, 3'b001, 1'b1, 32'hABCD1234, 32'hFFFFABCD};
`endif

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    RST_N = 1'b0;
    ALUResult = 32'h4; WriteData = 32'h12345678;
    MemWrite = 1'b1; MemRead = 1'b1; Funct3 = 3'b000;
    #1;
    check("rst_stall", {31'b0, Stall}, 32'h0);
    check("rst_we", {31'b0, MemWE}, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    check("rst_mis", {31'b0, MisalignErr}, 32'h0);
    tick();
    tick();
    MemWrite = 1'b0; MemRead = 1'b0;
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      mem[vecs[i].addr[5:2]] = vecs[i].word;
      ALUResult = vecs[i].addr;
      Funct3    = vecs[i].f3;
      MemRead   = vecs[i].rd;
      MemWrite  = 1'b0;
      #1;
      check($sformatf("load[%0d]", i), ReadData, vecs[i].exp);
      check($sformatf("load_stall[%0d]", i), {31'b0, Stall}, 32'h0);
    end
    MemRead = 1'b0;
    tick();

    // SW then LW
    ALUResult = 32'h8; WriteData = 32'hDEADBEEF; Funct3 = 3'b010; MemWrite = 1'b1;
    #1;
    check("sw_addr", MemAddr, 32'h2);
    check("sw_we", {31'b0, MemWE}, 32'h1);
    check("sw_stall", {31'b0, Stall}, 32'h0);
    check("sw_wdata", MemWData, 32'hDEADBEEF);
    tick();
    MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    check("lw_we", {31'b0, MemWE}, 32'h0);
    check("lw_data", ReadData, 32'hDEADBEEF);
    MemRead = 1'b0;

    // store with MemRead also set: store wins, no load data
    ALUResult = 32'hC; WriteData = 32'h0BADF00D; Funct3 = 3'b010;
    MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    check("prio_rdata", ReadData, 32'h0);
    check("prio_we", {31'b0, MemWE}, 32'h1);
    tick();
    MemWrite = 1'b0; MemRead = 1'b0;
    check("prio_mem", mem[3], 32'h0BADF00D);

    // SB read-modify-write
    mem[1] = 32'h11223344;
    ALUResult = 32'h6; WriteData = 32'hFFFFFFAA; Funct3 = 3'b000; MemWrite = 1'b1;
    #1;
    check("sb_stall1", {31'b0, Stall}, 32'h1);
    check("sb_we1", {31'b0, MemWE}, 32'h0);
    tick();
    ALUResult = 32'h30; WriteData = 32'h0; MemWrite = 1'b1; Funct3 = 3'b010;
    #1;
    check("sb_stall2", {31'b0, Stall}, 32'h1);
    check("sb_we2", {31'b0, MemWE}, 32'h0);
    check("sb_addr2", MemAddr, 32'h1);
    tick();
    MemWrite = 1'b0;
    #1;
    check("sb_stall3", {31'b0, Stall}, 32'h0);
    check("sb_we3", {31'b0, MemWE}, 32'h1);
    check("sb_addr3", MemAddr, 32'h1);
    check("sb_wdata3", MemWData, 32'h11AA3344);
    tick();
    check("sb_mem", mem[1], 32'h11AA3344);
    check("sb_idle_we", {31'b0, MemWE}, 32'h0);

    // SH upper half
    mem[3] = 32'hCAFEBABE;
    ALUResult = 32'hE; WriteData = 32'h55551234; Funct3 = 3'b001; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    tick();
    check("sh_wdata", MemWData, 32'h1234BABE);
    tick();
    check("sh_mem", mem[3], 32'h1234BABE);

    // store with unsupported size is a no-op
    ALUResult = 32'h8; WriteData = 32'h0; Funct3 = 3'b100; MemWrite = 1'b1;
    #1;
    check("noop_we", {31'b0, MemWE}, 32'h0);
    check("noop_stall", {31'b0, Stall}, 32'h0);
    tick();
    MemWrite = 1'b0;
    check("noop_next_stall", {31'b0, Stall}, 32'h0);
    check("noop_mem", mem[2], 32'hDEADBEEF);

    // reset in MERGE aborts SH
    mem[4] = 32'h01020304;
    ALUResult = 32'h10; WriteData = 32'h0000BEEF; Funct3 = 3'b001; MemWrite = 1'b1;
    tick();
    check("abort_merge_stall", {31'b0, Stall}, 32'h1);
    RST_N = 1'b0;
    #1;
    check("abort_stall", {31'b0, Stall}, 32'h0);
    check("abort_we", {31'b0, MemWE}, 32'h0);
    tick();
    MemWrite = 1'b0;
    RST_N = 1'b1;
    #1;
    check("abort_idle_stall", {31'b0, Stall}, 32'h0);
    check("abort_idle_we", {31'b0, MemWE}, 32'h0);
    tick();
    tick();
    check("abort_mem", mem[4], 32'h01020304);
    ALUResult = 32'h10; WriteData = 32'h77777777; Funct3 = 3'b010; MemWrite = 1'b1;
    #1;
    check("abort_then_sw_we", {31'b0, MemWE}, 32'h1);
    tick();
    MemWrite = 1'b0;
    check("abort_then_sw_mem", mem[4], 32'h77777777);

    // misaligned SW
    mem[1] = 32'h0;
    ALUResult = 32'h5; WriteData = 32'h55667788; Funct3 = 3'b010; MemWrite = 1'b1;
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_we", {31'b0, MemWE}, 32'h0);
    check("mis_stall", {31'b0, Stall}, 32'h0);
    tick();
    MemWrite = 1'b0;
    tick();
    check("mis_flag", {31'b0, MisalignErr}, 32'h1);
    check("mis_mem", mem[1], 32'h0);
    tick();
    check("mis_flag_held", {31'b0, MisalignErr}, 32'h1);
`else
    check("mis_we", {31'b0, MemWE}, 32'h1);
    check("mis_addr", MemAddr, 32'h1);
    tick();
    MemWrite = 1'b0;
    check("mis_mem", mem[1], 32'h55667788);
    check("mis_flag", {31'b0, MisalignErr}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port ALUResult, input, 32, byte address from ALU.
REQ-004 SHALL have port WriteData, input, 32, store data (rs2).
REQ-005 SHALL have ports MemWrite and MemRead, input, 1 each, store and load requests.
REQ-006 SHALL have port Funct3, input, 3, access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port ReadData, output, 32, extended load result to writeback.
REQ-008 SHALL have port Stall, output, 1, holds PC and pipeline when 1.
REQ-009 SHALL have port MemAddr, output, 32, word index to data memory, equal to {2'b00, addr[31:2]}.
REQ-010 SHALL have ports MemWData (output, 32), MemWE (output, 1) and MemRData (input, 32), the data memory write data, write enable and combinational read word.
REQ-011 SHALL have port MisalignErr, output, 1, sticky misaligned-access flag.

Function
REQ-012 Loads SHALL be combinational with zero latency: select the byte or halfword from MemRData by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU); W passes through.
REQ-013 ReadData SHALL be 0 when MemRead=0, or when Funct3 is 011, 110 or 111.
REQ-014 SW SHALL complete in one cycle in IDLE: MemWE=1, MemWData=WriteData, Stall=0.
REQ-015 SB and SH SHALL use a 3-state read-modify-write FSM with states IDLE, MERGE and WRITE.
REQ-016 IDLE->MERGE on MemWrite with Funct3 000 or 001; Stall=1 in that cycle; address, data, Funct3 captured.
REQ-017 MERGE SHALL register MemRData (old word) and set Stall=1, MemWE=0; the next state is WRITE.
REQ-018 WRITE SHALL drive MemAddr from the captured address, with MemWData equal to the old word with the target byte or halfword replaced by captured WriteData[7:0] or [15:0] at lane addr[1:0]; it SHALL also drive MemWE=1 and Stall=0; the next state is IDLE.
REQ-019 An SB/SH store SHALL therefore retire at the end of cycle 3; core inputs are ignored while in MERGE or WRITE.
REQ-020 When MemWrite=1 and MemRead=1, MemWrite SHALL take priority and ReadData SHALL be 0.
REQ-021 A store with Funct3 outside {000, 001, 010} SHALL be a no-op: MemWE=0, Stall=0, state stays IDLE.
REQ-022 MemAddr SHALL wrap naturally at 2^30 words; there is no bounds check.

Reset
REQ-023 RST_N=0 SHALL immediately force state IDLE, Stall=0, MemWE=0, MisalignErr=0, and clear the captured registers.
REQ-024 Reset asserted while in MERGE or WRITE SHALL abort the store with no memory write.
REQ-025 ReadData SHALL be 0 during reset.

Configuration
REQ-026 With macro LSU_MISALIGN_TRAP_EN defined, an H/HU access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL force MemWE=0 and ReadData=0, SHALL not enter MERGE, and SHALL set MisalignErr=1 until reset.
REQ-027 Without LSU_MISALIGN_TRAP_EN, the low address bits SHALL be truncated to natural alignment (H uses addr[1], W ignores addr[1:0]) and MisalignErr SHALL be tied to 0.

Verification
REQ-028 SW with addr 0x8 and data 0xDEADBEEF SHALL give MemAddr=2, MemWE=1 for 1 cycle and Stall=0; a following LW with addr 0x8 SHALL return 0xDEADBEEF.
REQ-029 With the word at index 1 holding 0x11223344, SB with addr 0x6 and data 0xAA SHALL give Stall=1,1,0 and a cycle-3 write of 0x11AA3344.
REQ-030 With the word holding 0x0000F080, LB with addr[1:0]=0 SHALL return 0xFFFFFF80, LBU 0x00000080, LH 0xFFFFF080 and LHU 0x0000F080.
REQ-031 RST_N asserted in MERGE during an SH SHALL give no MemWE pulse, Stall=0 at once and state IDLE.
REQ-032 With LSU_MISALIGN_TRAP_EN, SW with addr 0x5 SHALL give MemWE=0 and MisalignErr=1 held; without it, the same store SHALL write at index 1.
